// File: rtl/modmul_bank.sv
// Shared bank of PASTA_S pipelined multipliers mod 65537 serving mat_mul and the S-box.
// Four-stage pipeline; mat_mul wins arbitration; one vector accepted per cycle.
module modmul_bank #(
  parameter int unsigned BITLEN  = 17,
  parameter int unsigned PASTA_S = 32
) (
  input  logic                      clk,
  input  logic                      rst_mb,
  input  logic                      req_mm,
  input  logic [BITLEN*PASTA_S-1:0] modmul_in1_mm,
  input  logic [BITLEN*PASTA_S-1:0] modmul_in2_mm,
  input  logic                      req_sb,
  input  logic [BITLEN*PASTA_S-1:0] modmul_in1_sb,
  input  logic [BITLEN*PASTA_S-1:0] modmul_in2_sb,
  output logic                      gnt_mm,
  output logic                      gnt_sb,
  output logic [BITLEN*PASTA_S-1:0] modmul_out,
  output logic                      out_valid,
  output logic                      out_tag,
  output logic                      idle
);

  localparam int unsigned       Q       = 65537;
  localparam int unsigned       LATENCY = 4;
  localparam int unsigned       PW      = 2 * BITLEN - 1;
  localparam logic [BITLEN-1:0] QMod    = BITLEN'(Q);

  logic [BITLEN-1:0] a_d [PASTA_S];
  logic [BITLEN-1:0] b_d [PASTA_S];
  logic [BITLEN-1:0] a_q [PASTA_S];
  logic [BITLEN-1:0] b_q [PASTA_S];
  logic [PW-1:0]     p_d [PASTA_S];
  logic [PW-1:0]     p_q [PASTA_S];
  logic [BITLEN:0]   d_d [PASTA_S];
  logic [BITLEN:0]   d_q [PASTA_S];
  logic [BITLEN-1:0] r_d [PASTA_S];
  logic [BITLEN-1:0] r_q [PASTA_S];
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] tag_q;

  // Any 17-bit value is below 2q, so one conditional subtract is a full reduction.
  function automatic logic [BITLEN-1:0] pre_reduce(input logic [BITLEN-1:0] x);
    return (x >= QMod) ? x - QMod : x;
  endfunction

  assign gnt_mm = req_mm & ~rst_mb;
  assign gnt_sb = req_sb & ~req_mm & ~rst_mb;

  always_comb begin
    for (int i = 0; i < PASTA_S; i++) begin
      a_d[i] = pre_reduce(gnt_mm ? modmul_in1_mm[i*BITLEN +: BITLEN]
                                 : modmul_in1_sb[i*BITLEN +: BITLEN]);
      b_d[i] = pre_reduce(gnt_mm ? modmul_in2_mm[i*BITLEN +: BITLEN]
                                 : modmul_in2_sb[i*BITLEN +: BITLEN]);
    end
  end

  // 2^16 == -1 mod q: p = hi*2^16 + lo reduces to lo - hi, then one conditional +q.
  always_comb begin
    for (int i = 0; i < PASTA_S; i++) begin
      p_d[i] = {{(PW-BITLEN){1'b0}}, a_q[i]} * {{(PW-BITLEN){1'b0}}, b_q[i]};
      d_d[i] = {2'b00, p_q[i][BITLEN-2:0]} - {1'b0, p_q[i][PW-1:BITLEN-1]};
      // Result lies in [0, q-1] < 2^17, so the wrapped 17-bit add is exact.
      r_d[i] = d_q[i][BITLEN] ? d_q[i][BITLEN-1:0] + QMod : d_q[i][BITLEN-1:0];
    end
  end

  always_comb begin
    modmul_out = '0;
    for (int i = 0; i < PASTA_S; i++) begin
      modmul_out[i*BITLEN +: BITLEN] = r_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst_mb) begin
    if (rst_mb) begin
      vld_q <= '0;
      tag_q <= '0;
      for (int i = 0; i < PASTA_S; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        p_q[i] <= '0;
        d_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], gnt_mm | gnt_sb};
      tag_q <= {tag_q[LATENCY-2:0], gnt_sb};
      for (int i = 0; i < PASTA_S; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        p_q[i] <= p_d[i];
        d_q[i] <= d_d[i];
        r_q[i] <= r_d[i];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign idle      = rst_mb | (~(req_mm | req_sb) & ~(|vld_q));

endmodule

// File: tb/tb_modmul_bank.sv
// Directed and table-driven checks for modmul_bank: arbitration, latency, reduction, reset.
module tb_modmul_bank;

  localparam int BL = 17;
  localparam int NS = 32;
  localparam int VW = BL * NS;

  logic          clk = 1'b0;
  logic          rst_mb;
  logic          req_mm, req_sb;
  logic [VW-1:0] in1_mm, in2_mm, in1_sb, in2_sb;
  logic          gnt_mm, gnt_sb;
  logic [VW-1:0] modmul_out;
  logic          out_valid, out_tag, idle;

  int n_chk  = 0;
  int n_pass = 0;

  modmul_bank #(.BITLEN(BL), .PASTA_S(NS)) dut (
    .clk           (clk),
    .rst_mb        (rst_mb),
    .req_mm        (req_mm),
    .modmul_in1_mm (in1_mm),
    .modmul_in2_mm (in2_mm),
    .req_sb        (req_sb),
    .modmul_in1_sb (in1_sb),
    .modmul_in2_sb (in2_sb),
    .gnt_mm        (gnt_mm),
    .gnt_sb        (gnt_sb),
    .modmul_out    (modmul_out),
    .out_valid     (out_valid),
    .out_tag       (out_tag),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  // Field index: 0..2 -> lanes 0..2, 3 -> lanes 3..30, 4 -> lane 31.
  typedef struct packed {
    logic           sb;
    logic [4:0][16:0] a;
    logic [4:0][16:0] b;
    logic [4:0][16:0] e;
  } vec_t;

  vec_t tbl [5];

  function automatic int fld(input int lane);
    if (lane < 3) return lane;
    if (lane == NS - 1) return 4;
    return 3;
  endfunction

  function automatic logic [16:0] mref(input logic [16:0] a, input logic [16:0] b);
    longint unsigned x, y;
    x = {47'd0, a} % 64'd65537;
    y = {47'd0, b} % 64'd65537;
    return 17'((x * y) % 64'd65537);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic sb_c, input logic [VW-1:0] a, input logic [VW-1:0] b);
    req_mm = ~sb_c;
    req_sb = sb_c;
    if (sb_c) begin
      in1_sb = a;
      in2_sb = b;
    end else begin
      in1_mm = a;
      in2_mm = b;
    end
  endtask

  task automatic release_reqs();
    req_mm = 1'b0;
    req_sb = 1'b0;
  endtask

  logic [VW-1:0] va, vb, ve, va2, vb2;
  logic [VW-1:0] exp_v [100];
  logic          exp_t [100];
  logic [16:0]   bv [6];
  logic [16:0]   ra, rb;
  logic          s;
  int            seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // lanes listed {31, default, 2, 1, 0}
    tbl[0].sb = 1'b0;
    tbl[0].a = {17'd2, 17'd2, 17'd2, 17'd256, 17'd65536};
    tbl[0].b = {17'd3, 17'd3, 17'd3, 17'd257, 17'd65536};
    tbl[0].e = {17'd6, 17'd6, 17'd6, 17'd255, 17'd1};
    tbl[1].sb = 1'b1;
    tbl[1].a = {17'd65535, 17'd7, 17'd256, 17'd131071, 17'd65537};
    tbl[1].b = {17'd65535, 17'd9, 17'd256, 17'd2, 17'd5};
    tbl[1].e = {17'd4, 17'd63, 17'd65536, 17'd65531, 17'd0};
    tbl[2].sb = 1'b0;
    tbl[2].a = {17'd65537, 17'd131071, 17'd65535, 17'd1, 17'd0};
    tbl[2].b = {17'd65537, 17'd131071, 17'd65536, 17'd65536, 17'd131071};
    tbl[2].e = {17'd0, 17'd9, 17'd2, 17'd65536, 17'd0};
    tbl[3].sb = 1'b1;
    tbl[3].a = {17'd1, 17'd65536, 17'd131071, 17'd65535, 17'd65536};
    tbl[3].b = {17'd1, 17'd65535, 17'd65536, 17'd1, 17'd2};
    tbl[3].e = {17'd1, 17'd2, 17'd3, 17'd65535, 17'd65535};
    tbl[4].sb = 1'b0;
    tbl[4].a = {17'd131071, 17'd0, 17'd65536, 17'd40000, 17'd12345};
    tbl[4].b = {17'd1, 17'd0, 17'd131071, 17'd3, 17'd1};
    tbl[4].e = {17'd65534, 17'd0, 17'd3, 17'd54463, 17'd12345};
    bv = '{17'd0, 17'd1, 17'd65535, 17'd65536, 17'd65537, 17'd131071};

    // Reset values, grants suppressed while in reset
    rst_mb = 1'b1;
    req_mm = 1'b0; req_sb = 1'b0;
    in1_mm = '0; in2_mm = '0; in1_sb = '0; in2_sb = '0;
    #1;
    req_mm = 1'b1; req_sb = 1'b1;
    #1;
    chk("rst_gnt_mm", {31'd0, gnt_mm}, 0);
    chk("rst_gnt_sb", {31'd0, gnt_sb}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_tag", {31'd0, out_tag}, 0);
    chkv("rst_out", modmul_out, '0);
    release_reqs();
    tick();
    rst_mb = 1'b0;
    tick();

    // Three requests in flight, then reset: none may emerge
    for (int i = 0; i < NS; i++) begin
      va[i*BL +: BL] = 17'd100;
      vb[i*BL +: BL] = 17'd100;
    end
    drive(1'b0, va, vb);
    repeat (3) tick();
    release_reqs();
    rst_mb = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_idle", {31'd0, idle}, 1);
    chkv("midrst_out", modmul_out, '0);
    tick();
    rst_mb = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    chk("midrst_none_emerge", seen, 0);

    // Table vectors, one at a time, exact latency
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NS; i++) begin
        va[i*BL +: BL] = tbl[k].a[fld(i)];
        vb[i*BL +: BL] = tbl[k].b[fld(i)];
        ve[i*BL +: BL] = tbl[k].e[fld(i)];
      end
      drive(tbl[k].sb, va, vb);
      tick();
      release_reqs();
      tick();
      tick();
      chk($sformatf("tbl%0d_early_valid", k), {31'd0, out_valid}, 0);
      tick();
      chk($sformatf("tbl%0d_valid", k), {31'd0, out_valid}, 1);
      chk($sformatf("tbl%0d_tag", k), {31'd0, out_tag}, {31'd0, tbl[k].sb});
      chkv($sformatf("tbl%0d_vec", k), modmul_out, ve);
      chk($sformatf("tbl%0d_lane31", k), {15'd0, modmul_out[31*BL +: BL]},
          {15'd0, tbl[k].e[4]});
    end
    repeat (4) tick();

    // Simultaneous requests: mm twice, sb waits with held operands
    for (int i = 0; i < NS; i++) begin
      va[i*BL +: BL]  = 17'd10;
      va2[i*BL +: BL] = 17'd20;
      vb[i*BL +: BL]  = 17'd300;
    end
    req_mm = 1'b1; in1_mm = va; in2_mm = va;
    req_sb = 1'b1; in1_sb = vb; in2_sb = vb;
    #1;
    chk("arb0_gnt_mm", {31'd0, gnt_mm}, 1);
    chk("arb0_gnt_sb", {31'd0, gnt_sb}, 0);
    tick();
    in1_mm = va2; in2_mm = va2;
    #1;
    chk("arb1_gnt_sb", {31'd0, gnt_sb}, 0);
    tick();
    req_mm = 1'b0;
    #1;
    chk("arb2_gnt_sb", {31'd0, gnt_sb}, 1);
    tick();
    req_sb = 1'b0;
    tick();
    chk("arb_out0_valid", {31'd0, out_valid}, 1);
    chk("arb_out0_tag", {31'd0, out_tag}, 0);
    chk("arb_out0_lane0", {15'd0, modmul_out[BL-1:0]}, 100);
    tick();
    chk("arb_out1_valid", {31'd0, out_valid}, 1);
    chk("arb_out1_tag", {31'd0, out_tag}, 0);
    chk("arb_out1_lane0", {15'd0, modmul_out[BL-1:0]}, 400);
    tick();
    chk("arb_out2_valid", {31'd0, out_valid}, 1);
    chk("arb_out2_tag", {31'd0, out_tag}, 1);
    chk("arb_out2_lane31", {15'd0, modmul_out[31*BL +: BL]}, 24463);
    repeat (4) tick();

    // 100 back-to-back random requests
    chk("rand_idle_before", {31'd0, idle}, 1);
    for (int c = 0; c < 104; c++) begin
      if (c < 100) begin
        s = 1'($urandom_range(0, 1));
        for (int i = 0; i < NS; i++) begin
          ra = 17'($urandom_range(0, 131071));
          rb = 17'($urandom_range(0, 131071));
          va[i*BL +: BL] = ra;
          vb[i*BL +: BL] = rb;
          ve[i*BL +: BL] = mref(ra, rb);
        end
        drive(s, va, vb);
        exp_v[c] = ve;
        exp_t[c] = s;
      end else begin
        release_reqs();
      end
      if (c == 0) begin
        #1;
        chk("rand_idle_first_req", {31'd0, idle}, 0);
      end
      tick();
      if (c >= 3 && c <= 102) begin
        chk($sformatf("rand%0d_valid", c - 3), {31'd0, out_valid}, 1);
        chk($sformatf("rand%0d_tag", c - 3), {31'd0, out_tag}, {31'd0, exp_t[c-3]});
        chkv($sformatf("rand%0d_vec", c - 3), modmul_out, exp_v[c-3]);
      end
      if (c == 102) chk("rand_idle_last_out", {31'd0, idle}, 0);
      if (c == 103) begin
        chk("rand_idle_back", {31'd0, idle}, 1);
        chk("rand_valid_ends", {31'd0, out_valid}, 0);
      end
    end

    // Boundary operands, all 36 pairs spread over two back-to-back vectors
    for (int i = 0; i < NS; i++) begin
      va[i*BL +: BL]  = bv[i / 6];
      vb[i*BL +: BL]  = bv[i % 6];
      va2[i*BL +: BL] = bv[((32 + i) % 36) / 6];
      vb2[i*BL +: BL] = bv[((32 + i) % 36) % 6];
    end
    drive(1'b0, va, vb);
    tick();
    drive(1'b1, va2, vb2);
    tick();
    release_reqs();
    tick();
    tick();
    for (int i = 0; i < NS; i++)
      chk($sformatf("bnd0_lane%0d", i), {15'd0, modmul_out[i*BL +: BL]},
          {15'd0, mref(va[i*BL +: BL], vb[i*BL +: BL])});
    tick();
    chk("bnd1_tag", {31'd0, out_tag}, 1);
    for (int i = 0; i < NS; i++)
      chk($sformatf("bnd1_lane%0d", i), {15'd0, modmul_out[i*BL +: BL]},
          {15'd0, mref(va2[i*BL +: BL], vb2[i*BL +: BL])});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
